// File: rtl/booth_mult_seq_pkg.sv
// ---------------------------------------------------------------------------
// booth_mult_seq_pkg
// Shared definitions for the multiply/divide path:
//   - FSM state encoding of the sequential Booth multiplier
//   - Booth select encoding produced by booth_ctrl
//   - derivation of the number of radix-4 recoding steps
// No ports (package).
// ---------------------------------------------------------------------------
package booth_mult_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } mult_state_e;

  // Select encoding: bit 1 = negate, bit 0 = double the multiplicand.
  localparam logic [1:0] SEL_M      = 2'b00;
  localparam logic [1:0] SEL_2M     = 2'b01;
  localparam logic [1:0] SEL_NEG_M  = 2'b10;
  localparam logic [1:0] SEL_NEG_2M = 2'b11;

  // Radix-4 recoding retires two multiplier bits per step.
  function automatic int steps_f(input int width);
    return width / 2;
  endfunction

endpackage

// File: rtl/booth_ctrl.sv
// ---------------------------------------------------------------------------
// booth_ctrl
// Radix-4 modified-Booth recoder for one multiplier bit triplet.
// Ports:
//   triplet_i [2:0] : {q[1], q[0], q_m1}
//   en_o            : 1 when the partial product is non-zero
//   sel_o     [1:0] : SEL_* code choosing +M, +2M, -M or -2M
// ---------------------------------------------------------------------------
module booth_ctrl
  import booth_mult_seq_pkg::*;
(
  input  logic [2:0] triplet_i,
  output logic       en_o,
  output logic [1:0] sel_o
);

  // Triplet to partial-product select decode.
  always_comb begin
    en_o  = 1'b1;
    sel_o = SEL_M;
    case (triplet_i)
      3'b000:  begin en_o = 1'b0; sel_o = SEL_M;      end
      3'b001:  begin en_o = 1'b1; sel_o = SEL_M;      end
      3'b010:  begin en_o = 1'b1; sel_o = SEL_M;      end
      3'b011:  begin en_o = 1'b1; sel_o = SEL_2M;     end
      3'b100:  begin en_o = 1'b1; sel_o = SEL_NEG_2M; end
      3'b101:  begin en_o = 1'b1; sel_o = SEL_NEG_M;  end
      3'b110:  begin en_o = 1'b1; sel_o = SEL_NEG_M;  end
      3'b111:  begin en_o = 1'b0; sel_o = SEL_M;      end
      default: begin en_o = 1'b0; sel_o = SEL_M;      end
    endcase
  end

endmodule

// File: rtl/booth_mult_seq.sv
// ---------------------------------------------------------------------------
// booth_mult_seq
// Sequential radix-4 modified-Booth signed multiplier. One recoding step per
// clock; the result is valid for one cycle (data_resultRDY) WIDTH/2 edges
// after the start edge.
// Ports:
//   clock          : rising-edge clock
//   reset          : asynchronous active-high reset, clears all state
//   ctrl_MULT      : start pulse, operands sampled on the same edge
//   data_operandA  : multiplicand M (two's complement)
//   data_operandB  : multiplier Q (two's complement)
//   data_result    : low WIDTH bits of the product
//   data_exception : product does not fit in WIDTH signed bits
//   data_resultRDY : one-cycle result-valid pulse
// ---------------------------------------------------------------------------
module booth_mult_seq
  import booth_mult_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam int STEPS = steps_f(WIDTH);
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  // Accumulator carries two guard bits so that +/-2M never overflows.
  localparam int AW    = WIDTH + 2;

  mult_state_e      state_q, state_d;
  logic [AW-1:0]    m_q, m_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qm1_q, qm1_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rdy_q, rdy_d;

  logic             en_s;
  logic [1:0]       sel_s;
  logic             neg_s;
  logic [AW-1:0]    addend_s;
  logic [AW-1:0]    operand_s;
  logic [AW-1:0]    sum_s;
  logic [WIDTH:0]   ovf_chk_s;

  booth_ctrl u_booth_ctrl (
    .triplet_i ({q_q[1:0], qm1_q}),
    .en_o      (en_s),
    .sel_o     (sel_s)
  );

  // Add/subtract of 0, M or 2M; subtraction is invert plus carry-in.
  always_comb begin
    neg_s = (sel_s == SEL_NEG_M) || (sel_s == SEL_NEG_2M);
    if ((sel_s == SEL_2M) || (sel_s == SEL_NEG_2M)) begin
      addend_s = {m_q[AW-2:0], 1'b0};
    end else begin
      addend_s = m_q;
    end
    if (!en_s) begin
      operand_s = {AW{1'b0}};
    end else if (neg_s) begin
      operand_s = ~addend_s;
    end else begin
      operand_s = addend_s;
    end
    sum_s = acc_q + operand_s + {{(AW-1){1'b0}}, (en_s & neg_s)};
  end

  // Next-state, datapath and ready-pulse logic; a load overrides every state.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    rdy_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_RUN: begin
        // Arithmetic shift right by 2 of {sum, q, q_m1}.
        acc_d = {{2{sum_s[AW-1]}}, sum_s[AW-1:2]};
        q_d   = {sum_s[1:0], q_q[WIDTH-1:2]};
        qm1_d = q_q[1];
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == CW'(STEPS - 1)) begin
          state_d = ST_DONE;
          rdy_d   = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (ctrl_MULT) begin
      state_d = ST_RUN;
      m_d     = {{2{data_operandA[WIDTH-1]}}, data_operandA};
      acc_d   = {AW{1'b0}};
      q_d     = data_operandB;
      qm1_d   = 1'b0;
      cnt_d   = {CW{1'b0}};
      rdy_d   = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      m_q     <= {AW{1'b0}};
      acc_q   <= {AW{1'b0}};
      q_q     <= {WIDTH{1'b0}};
      qm1_q   <= 1'b0;
      cnt_q   <= {CW{1'b0}};
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
    end
  end

  // Product fits in WIDTH signed bits only if the upper half is pure sign.
  assign ovf_chk_s      = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign data_exception = (|ovf_chk_s) & ~(&ovf_chk_s);
  assign data_result    = q_q;
  assign data_resultRDY = rdy_q;

endmodule
